// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port SRAM: serializes byte accesses from
// requesters A and B, drives CEB/CMD/ADD/DIN, and routes read data back through
// a tag pipeline that tracks which requester issued each read.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic              gnt_a_o,
  output logic              rvalid_a_o,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              req_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
  output logic              gnt_b_o,
  output logic              rvalid_b_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic              ceb_o,
  output logic              cmd_o,
  output logic [ADDR_W-1:0] add_o,
  output logic [DATA_W-1:0] din_o,
  input  logic [DATA_W-1:0] q_i,
  output logic [15:0]       conflict_cnt_o
);

  localparam int unsigned CNT_W = 16;
  // One stage per cycle from grant edge to the edge before Q is captured.
  localparam int unsigned TAG_N = RD_LAT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic FIXED_PRIO = (ARB_MODE == 1);

  logic              elig_a_c, elig_b_c, win_a_c, win_b_c, win_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic              last_a_q, last_a_d;
  logic              ceb_q, ceb_d, cmd_q, cmd_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_N-1:0]  tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

  // Arbitration: a requester is eligible only outside its own grant cycle.
  always_comb begin
    elig_a_c = req_a_i & ~gnt_a_q;
    elig_b_c = req_b_i & ~gnt_b_q;
    win_a_c  = 1'b0;
    win_b_c  = 1'b0;
    if (elig_a_c && elig_b_c) begin
      win_a_c = FIXED_PRIO | ~last_a_q;
      win_b_c = ~win_a_c;
    end else begin
      win_a_c = elig_a_c;
      win_b_c = elig_b_c;
    end
    win_c       = win_a_c | win_b_c;
    sel_we_c    = win_b_c ? we_b_i    : we_a_i;
    sel_addr_c  = win_b_c ? addr_b_i  : addr_a_i;
    sel_wdata_c = win_b_c ? wdata_b_i : wdata_a_i;
  end

  // Next-state: SRAM command, pointer, conflict counter, tag pipe and read return.
  always_comb begin
    gnt_a_d    = win_a_c;
    gnt_b_d    = win_b_c;
    last_a_d   = last_a_q;
    ceb_d      = 1'b1;
    cmd_d      = 1'b1;
    add_d      = add_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    if (win_c) begin
      last_a_d = win_a_c;
      ceb_d    = 1'b0;
      cmd_d    = ~sel_we_c;
      add_d    = sel_addr_c;
      din_d    = sel_we_c ? sel_wdata_c : '0;
    end
    if (elig_a_c && elig_b_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tag_vld_d  = {tag_vld_q[TAG_N-2:0], win_c & ~sel_we_c};
    tag_id_d   = {tag_id_q[TAG_N-2:0], win_b_c};
    rvalid_a_d = tag_vld_q[TAG_N-1] & ~tag_id_q[TAG_N-1];
    rvalid_b_d = tag_vld_q[TAG_N-1] &  tag_id_q[TAG_N-1];
    if (rvalid_a_d) rdata_a_d = q_i;
    if (rvalid_b_d) rdata_b_d = q_i;
  end

  // State registers; reset drops all in-flight read tags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      last_a_q   <= 1'b0;
      ceb_q      <= 1'b1;
      cmd_q      <= 1'b1;
      add_q      <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      last_a_q   <= last_a_d;
      ceb_q      <= ceb_d;
      cmd_q      <= cmd_d;
      add_q      <= add_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign gnt_a_o        = gnt_a_q;
  assign gnt_b_o        = gnt_b_q;
  assign rvalid_a_o     = rvalid_a_q;
  assign rvalid_b_o     = rvalid_b_q;
  assign rdata_a_o      = rdata_a_q;
  assign rdata_b_o      = rdata_b_q;
  assign ceb_o          = ceb_q;
  assign cmd_o          = cmd_q;
  assign add_o          = add_q;
  assign din_o          = din_q;
  assign conflict_cnt_o = cnt_q;

endmodule
